// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg -- shared types and constants for the transmit FIFO arbiter.
//   arb_state_e : arbiter state (IDLE, GRANT0, GRANT1)
//   TAG_*       : two-bit word tags written above the payload in the FIFO
//   grant_state / grant_onehot : map a requester index to its state / grant vector
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_e;

    localparam logic [1:0] TAG_DATA = 2'b00;
    localparam logic [1:0] TAG_EOP  = 2'b01;
    localparam logic [1:0] TAG_EEP  = 2'b10;

    function automatic arb_state_e grant_state(input logic idx);
        return idx ? GRANT1 : GRANT0;
    endfunction

    function automatic logic [1:0] grant_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/fifo_tx_arbiter_if.sv
// fifo_tx_arbiter_if -- requester handshake plus FIFO write port of the arbiter.
//   req_valid/req_data/req_eop/req_ready : two requesters, requester n at [n*W +: W]
//   grant                                : one-hot current owner, 0 when idle
//   w_en/w_data/fill_level               : FIFO write strobe, {tag, payload}, occupancy
//   timeout_pulse                        : one-cycle pulse when a forced EEP is written
// Modports: slave = arbiter, master = requesters + FIFO (environment).
interface fifo_tx_arbiter_if #(
    parameter int G_DATA_WIDTH_BITS = 8,
    parameter int G_ADDR_WIDTH_BITS = 6
);
    logic [1:0]                     req_valid;
    logic [2*G_DATA_WIDTH_BITS-1:0] req_data;
    logic [1:0]                     req_eop;
    logic [1:0]                     req_ready;
    logic [1:0]                     grant;
    logic                           w_en;
    logic [G_DATA_WIDTH_BITS+1:0]   w_data;
    logic [G_ADDR_WIDTH_BITS:0]     fill_level;
    logic                           timeout_pulse;

    modport slave (
        input  req_valid, req_data, req_eop, fill_level,
        output req_ready, grant, w_en, w_data, timeout_pulse
    );

    modport master (
        output req_valid, req_data, req_eop, fill_level,
        input  req_ready, grant, w_en, w_data, timeout_pulse
    );
endinterface

// File: rtl/fifo_arb_watchdog.sv
// fifo_arb_watchdog -- mid-packet stall counter for the transmit arbiter.
//   clk, rst   : clock, synchronous active-high reset
//   active_i   : a requester currently owns the FIFO
//   stall_i    : owner's req_valid is low this cycle
//   clear_i    : word accepted or packet closed this cycle
//   expired_o  : counter has reached G_TIMEOUT_CYCLES (held until cleared)
module fifo_arb_watchdog #(
    parameter int G_TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active_i,
    input  logic stall_i,
    input  logic clear_i,
    output logic expired_o
);
    localparam int CW = (G_TIMEOUT_CYCLES < 1) ? 1 : $clog2(G_TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q == CW'(G_TIMEOUT_CYCLES));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (!active_i || clear_i) begin
            cnt_d = '0;
        end else if (stall_i && !expired_o) begin
            // Saturate at the limit; the arbiter closes the packet from there.
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/fifo_tx_arbiter.sv
// fifo_tx_arbiter -- packet-granular round-robin arbiter sharing one transmit
// FIFO between two requesters ahead of the link encoder.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fifo_tx_arbiter_if.slave (requester handshake, FIFO write port,
//              fill level, grant, timeout pulse)
// Build option: define FIFO_ARB_TIMEOUT_EN to close a stalled packet with an
// EEP word after G_TIMEOUT_CYCLES idle cycles; otherwise the grant is held.
module fifo_tx_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int G_DATA_WIDTH_BITS = 8,
    parameter int G_ADDR_WIDTH_BITS = 6,
    parameter int G_TIMEOUT_CYCLES  = 255
) (
    input  logic               clk,
    input  logic               rst,
    fifo_tx_arbiter_if.slave   bus
);
    localparam int W     = G_DATA_WIDTH_BITS;
    localparam int DEPTH = 2 ** G_ADDR_WIDTH_BITS;

    arb_state_e   state_q;
    logic         last_served_q;
    logic [1:0]   grant_q;

    logic         granted;
    logic         owner;
    logic         full;
    logic         valid_n;
    logic         eop_n;
    logic [W-1:0] data_n;
    logic         accept;
    logic         eep_write;
    logic         pkt_done;
    logic         expired;

    assign granted = (state_q != IDLE);
    assign owner   = (state_q == GRANT1);
    // fill_level is exact: w_en is combinational, so nothing is in flight.
    assign full    = (bus.fill_level == (G_ADDR_WIDTH_BITS + 1)'(DEPTH));
    assign valid_n = owner ? bus.req_valid[1] : bus.req_valid[0];
    assign eop_n   = owner ? bus.req_eop[1]   : bus.req_eop[0];
    assign data_n  = owner ? bus.req_data[2*W-1 -: W] : bus.req_data[W-1:0];

    // Write path: combinational so the FIFO and the requester see the same edge.
    always_comb begin
        bus.req_ready = 2'b00;
        bus.w_en      = 1'b0;
        bus.w_data    = '0;
        accept        = 1'b0;
        eep_write     = 1'b0;
        if (!rst && granted) begin
            if (expired) begin
                // Stalled packet: terminate it with EEP once there is room.
                if (!full) begin
                    bus.w_en   = 1'b1;
                    bus.w_data = {TAG_EEP, {W{1'b0}}};
                    eep_write  = 1'b1;
                end
            end else begin
                bus.req_ready = owner ? {!full, 1'b0} : {1'b0, !full};
                accept        = valid_n && !full;
                if (accept) begin
                    bus.w_en   = 1'b1;
                    bus.w_data = {eop_n ? TAG_EOP : TAG_DATA, data_n};
                end
            end
        end
    end

    assign pkt_done          = (accept && eop_n) || eep_write;
    assign bus.grant         = grant_q;
    assign bus.timeout_pulse = eep_write;

`ifdef FIFO_ARB_TIMEOUT_EN
    fifo_arb_watchdog #(
        .G_TIMEOUT_CYCLES (G_TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .active_i  (granted),
        .stall_i   (!valid_n),
        .clear_i   (accept || eep_write),
        .expired_o (expired)
    );
`else
    assign expired = 1'b0;
`endif

    // Arbiter FSM; grant is registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            last_served_q <= 1'b1;
            grant_q       <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (&bus.req_valid) begin
                        // Both waiting: the one not served last goes first.
                        state_q <= grant_state(!last_served_q);
                        grant_q <= grant_onehot(!last_served_q);
                    end else if (bus.req_valid[0]) begin
                        state_q <= GRANT0;
                        grant_q <= 2'b01;
                    end else if (bus.req_valid[1]) begin
                        state_q <= GRANT1;
                        grant_q <= 2'b10;
                    end
                end
                default: begin
                    // Grant is held through valid gaps and full stalls until
                    // the packet is closed by EOP or a forced EEP.
                    if (pkt_done) begin
                        state_q       <= IDLE;
                        grant_q       <= 2'b00;
                        last_served_q <= owner;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_tx_arbiter.sv
// tb_fifo_tx_arbiter -- self-checking bench for fifo_tx_arbiter.
// Drivers push the FIFO word each requester should produce into a per-requester
// queue; a monitor pops and compares on every FIFO write, and also checks grant
// shape, packet contiguity and the no-write-when-full rule.
module tb_fifo_tx_arbiter;
    import fifo_arb_pkg::*;

    localparam int W      = 8;
    localparam int A      = 6;
    localparam int TO     = 4;
    localparam int DEPTH  = 64;
    localparam int BUDGET = 2000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_tx_arbiter_if #(.G_DATA_WIDTH_BITS(W), .G_ADDR_WIDTH_BITS(A)) bus ();

    fifo_tx_arbiter #(
        .G_DATA_WIDTH_BITS (W),
        .G_ADDR_WIDTH_BITS (A),
        .G_TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [W+1:0] exp_q0[$];
    logic [W+1:0] exp_q1[$];
    int           order_q[$];
    bit           mon_in_pkt = 1'b0;
    int           mon_owner  = 0;
    bit           rand_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_exp(input int n, input logic [W+1:0] v);
        if (n == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
    endfunction

    function automatic int order_code();
        int r = 0;
        foreach (order_q[i]) r = (r << 1) | order_q[i];
        return r;
    endfunction

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin : monitor
        int           owner;
        logic [W+1:0] e;
        if (rst) begin
            check("w_en_in_reset", 32'(bus.w_en), 0);
            mon_in_pkt = 1'b0;
        end else begin
            if (bus.fill_level == (A+1)'(DEPTH))
                check("no_write_when_full", 32'(bus.w_en), 0);
            if (bus.w_en) begin
                owner = (bus.grant == 2'b10) ? 1 : 0;
                check("grant_onehot_on_write", 32'(bus.grant == 2'b01 || bus.grant == 2'b10), 1);
                if (mon_in_pkt) check("no_interleave", owner, mon_owner);
                if (owner == 0 && exp_q0.size() == 0) begin
                    check("unexpected_write_r0", exp_q0.size(), 1);
                end else if (owner == 1 && exp_q1.size() == 0) begin
                    check("unexpected_write_r1", exp_q1.size(), 1);
                end else begin
                    e = (owner == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    check("w_data", 32'(bus.w_data), 32'(e));
                end
                mon_owner  = owner;
                mon_in_pkt = (bus.w_data[W+1:W] == TAG_DATA);
                order_q.push_back(owner);
            end
        end
    end

    // Presents one word and waits (bounded) for its accept; returns aligned
    // at posedge+1 with valid dropped.
    task automatic drive_word(input int n, input logic [W-1:0] d, input logic eop,
                              output int waited);
        bus.req_valid[n]          = 1'b1;
        bus.req_eop[n]            = eop;
        bus.req_data[n*W +: W]    = d;
        push_exp(n, {eop ? TAG_EOP : TAG_DATA, d});
        waited = 0;
        forever begin
            @(negedge clk);
            waited++;
            if (bus.req_valid[n] && bus.req_ready[n]) break;
            if (waited >= BUDGET) begin
                check("accept_timeout", waited, 0);
                break;
            end
        end
        @(posedge clk); #1;
        bus.req_valid[n] = 1'b0;
        bus.req_eop[n]   = 1'b0;
    endtask

    task automatic send_packet(input int n, input int len, input logic [W-1:0] base,
                               input int max_gap, input bit rnd, output int cycles);
        int w;
        int gap;
        logic [W-1:0] d;
        cycles = 0;
        for (int i = 0; i < len; i++) begin
            if (i > 0 && max_gap > 0) begin
                gap = int'($urandom_range(0, max_gap));
                repeat (gap) begin @(posedge clk); #1; end
                cycles += gap;
            end
            d = rnd ? W'($urandom) : base + W'(i);
            drive_word(n, d, i == len - 1, w);
            cycles += w;
        end
    endtask

    task automatic apply_reset();
        rst           = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_eop   = 2'b00;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
    endtask

    initial begin : global_watchdog
        #500_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin : main
        int c, c0, c1, w;

        rst            = 1'b1;
        bus.req_valid  = 2'b00;
        bus.req_data   = '0;
        bus.req_eop    = 2'b00;
        bus.fill_level = '0;
        @(posedge clk); #1;

        // Reset values.
        @(negedge clk);
        check("rst_grant", 32'(bus.grant), 0);
        check("rst_req_ready", 32'(bus.req_ready), 0);
        check("rst_w_en", 32'(bus.w_en), 0);
        check("rst_w_data", 32'(bus.w_data), 0);
        check("rst_timeout_pulse", 32'(bus.timeout_pulse), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single packet from requester 0: one IDLE cycle, then 3 writes.
        c = 0;
        drive_word(0, 8'h11, 1'b0, w); c += w;
        drive_word(0, 8'h22, 1'b0, w); c += w;
        drive_word(0, 8'h33, 1'b1, w); c += w;
        check("single_pkt_cycles", c, 4);
        @(negedge clk);
        check("dead_cycle_grant", 32'(bus.grant), 0);
        check("dead_cycle_w_en", 32'(bus.w_en), 0);
        @(posedge clk); #1;

        // Simultaneous requests from reset: requester 0 first.
        apply_reset();
        order_q.delete();
        fork
            send_packet(0, 2, 8'h20, 0, 1'b0, c0);
            send_packet(1, 2, 8'h40, 0, 1'b0, c1);
        join
        check("rr_from_reset_len", order_q.size(), 4);
        check("rr_from_reset_order", order_code(), 'b0011);
        // Last served is now requester 1, so requester 0 wins again.
        order_q.delete();
        fork
            send_packet(0, 2, 8'h24, 0, 1'b0, c0);
            send_packet(1, 2, 8'h44, 0, 1'b0, c1);
        join
        check("rr_again_order", order_code(), 'b0011);
        // Requester 0 alone, then both: requester 1 wins.
        order_q.delete();
        send_packet(0, 1, 8'h28, 0, 1'b0, c0);
        fork
            send_packet(0, 2, 8'h2a, 0, 1'b0, c0);
            send_packet(1, 2, 8'h4a, 0, 1'b0, c1);
        join
        check("rr_swap_order", order_code(), 'b01100);

        // Full stall during requester 1's packet.
        bus.fill_level = (A+1)'(DEPTH);
        fork
            send_packet(1, 2, 8'h60, 0, 1'b0, c);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("full_req_ready", 32'(bus.req_ready), 0);
                    check("full_w_en", 32'(bus.w_en), 0);
                end
                @(posedge clk); #1;
                bus.fill_level = (A+1)'(DEPTH - 1);
                @(negedge clk);
                check("write_after_drain", 32'(bus.w_en), 1);
                check("grant_during_stall", 32'(bus.grant), 'b10);
            end
        join
        check("full_stall_cycles", c, 7);
        bus.fill_level = '0;

        // Reset mid-packet after 2 of 4 words.
        drive_word(0, 8'ha1, 1'b0, w);
        drive_word(0, 8'ha2, 1'b0, w);
        bus.req_valid[0]   = 1'b1;
        bus.req_data[W-1:0] = 8'ha3;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req_valid[0] = 1'b0;
        @(negedge clk);
        check("post_reset_grant", 32'(bus.grant), 0);
        check("post_reset_w_en", 32'(bus.w_en), 0);
        @(posedge clk); #1;
        send_packet(1, 2, 8'h70, 0, 1'b0, c);
        check("post_reset_pkt_cycles", c, 3);

        // Requester 0 stalls mid-packet after 0x55.
        drive_word(0, 8'h55, 1'b0, w);
`ifdef FIFO_ARB_TIMEOUT_EN
        push_exp(0, {TAG_EEP, 8'h00});
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            check("stall_w_en", 32'(bus.w_en), 0);
            check("stall_pulse", 32'(bus.timeout_pulse), 0);
            check("stall_grant", 32'(bus.grant), 'b01);
        end
        @(negedge clk);
        check("eep_w_en", 32'(bus.w_en), 1);
        check("eep_pulse", 32'(bus.timeout_pulse), 1);
        @(negedge clk);
        check("after_eep_grant", 32'(bus.grant), 0);
        check("after_eep_pulse", 32'(bus.timeout_pulse), 0);
        @(posedge clk); #1;
        send_packet(0, 1, 8'h56, 0, 1'b0, c);
        check("new_pkt_after_eep_cycles", c, 2);
`else
        repeat (20) begin
            @(negedge clk);
            check("hold_grant", 32'(bus.grant), 'b01);
            check("hold_w_en", 32'(bus.w_en), 0);
            check("hold_pulse", 32'(bus.timeout_pulse), 0);
        end
        @(posedge clk); #1;
        drive_word(0, 8'h56, 1'b1, w);
        check("resume_immediate_accept", w, 1);
`endif

        // Randomised traffic with random fill-level pressure; in-packet gaps
        // stay below the stall limit so no EEP is expected.
        rand_done = 1'b0;
        fork
            begin
                fork
                    for (int p = 0; p < 15; p++) begin
                        send_packet(0, int'($urandom_range(1, 5)), '0, 2, 1'b1, c0);
                        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    end
                    for (int p = 0; p < 15; p++) begin
                        send_packet(1, int'($urandom_range(1, 5)), '0, 2, 1'b1, c1);
                        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    end
                join
                rand_done = 1'b1;
            end
            while (!rand_done) begin
                bus.fill_level = ($urandom_range(0, 3) == 0) ? (A+1)'(DEPTH)
                                                             : (A+1)'($urandom_range(0, DEPTH - 1));
                @(posedge clk); #1;
            end
        join
        bus.fill_level = '0;
        repeat (3) @(negedge clk);
        check("leftover_r0", exp_q0.size(), 0);
        check("leftover_r1", exp_q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
